// File: rtl/uart_block_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_block_sched
// Description : Round-robin scheduler for two 128-bit block sources. Each
//               granted block goes out MSB byte first, one byte per uart_tx
//               frame, with a programmable idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_block_sched #(
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         s0_valid,
  input  logic [127:0] s0_data,
  output logic         s0_ack,
  input  logic         s1_valid,
  input  logic [127:0] s1_data,
  output logic         s1_ack,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         busy,
  output logic [3:0]   byte_idx,
  output logic         done,
  output logic         err,
  output logic         last_src
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  // Terminal counts; the gap value is only reachable when GAP_CYCLES > 0.
  localparam logic [15:0] c_gap_last = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] c_tmo_last = 16'(BUSY_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [127:0]   shreg_q, shreg_d;      // top byte is the byte on the wire
  logic [3:0]     byte_idx_q, byte_idx_d;
  logic [15:0]    cnt_q, cnt_d;          // shared: busy timeout / gap count
  logic           tx_start_q, tx_start_d;
  logic           s0_ack_q, s0_ack_d;
  logic           s1_ack_q, s1_ack_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           last_src_q, last_src_d;
  logic           prio_q, prio_d;        // 1: source 1 wins a tie
  logic           busy_q, busy_d;
  logic           grant_src;

  // Next-state and next-output computation for the block sequencer.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    s0_ack_d   = 1'b0;
    s1_ack_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    last_src_d = last_src_q;
    prio_d     = prio_q;
    grant_src  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A frame still on the line (tx_busy) blocks any new grant.
        if (!tx_busy && (s0_valid || s1_valid)) begin
          grant_src  = (s0_valid && s1_valid) ? prio_q : s1_valid;
          shreg_d    = grant_src ? s1_data : s0_data;
          byte_idx_d = 4'd0;
          s0_ack_d   = ~grant_src;
          s1_ack_d   = grant_src;
          last_src_d = grant_src;
          prio_d     = ~grant_src;
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == c_tmo_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx_q == 4'd15) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            shreg_d    = {shreg_q[119:0], 8'h00};
            byte_idx_d = byte_idx_q + 4'd1;
            if (GAP_CYCLES == 0) begin
              tx_start_d = 1'b1;
              state_d    = ST_START;
            end else begin
              cnt_d   = 16'd0;
              state_d = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == c_gap_last) begin
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any partial block.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= 128'd0;
      byte_idx_q <= 4'd0;
      cnt_q      <= 16'd0;
      tx_start_q <= 1'b0;
      s0_ack_q   <= 1'b0;
      s1_ack_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_src_q <= 1'b0;
      prio_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      s0_ack_q   <= s0_ack_d;
      s1_ack_q   <= s1_ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_src_q <= last_src_d;
      prio_q     <= prio_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = shreg_q[127:120];
  assign tx_start = tx_start_q;
  assign s0_ack   = s0_ack_q;
  assign s1_ack   = s1_ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign last_src = last_src_q;
  assign busy     = busy_q;
  assign byte_idx = byte_idx_q;

endmodule
`default_nettype wire
